uart_dump_ctrl_n: RTL and testbench
===================================

Name: uart_dump_ctrl_n

Overview:
- Parametrised UART command responder. Decodes single-byte commands from the UART receiver and streams one of N_SRC packed byte vectors to the UART transmitter, one byte per transmitter handshake.
- Successor to the fixed three-source dump logic. Adds:
  - per-source runtime lengths
  - a coherent snapshot of the selected source at command acceptance
  - a dropped-command counter and busy flag
  - optional checksum trailer
- Sits between the UART rx/tx pair and the register file / timing-receiver packet logic on the 10 MHz domain.

Parameters:
- N_SRC, 3: number of dumpable sources.
- MAX_BYTES, 32: maximum bytes per source; sets the vector width per source.
- LEN_W, $clog2(MAX_BYTES+1): width of each length field.
- CMD_BASE, 8'hAB: source s is selected by command byte CMD_BASE+s, for s in 0..N_SRC-1.
- ECHO_UNKNOWN, 1: when 1, unrecognised bytes are echoed; when 0, they are silently discarded.

Ports:
- i_clk_10  in  1  system clock (10 MHz).
- i_rst  in  1  synchronous, active-high reset.
- i_rx_byte  in  8  received byte.
- i_rx_dv  in  1  one-cycle strobe; i_rx_byte valid.
- i_tx_done  in  1  one-cycle strobe; transmitter finished the current byte.
- i_src_data  in  N_SRC*MAX_BYTES*8  source s byte b is at bits [(s*MAX_BYTES+b)*8 +: 8].
- i_src_len  in  N_SRC*LEN_W  byte count of source s at [s*LEN_W +: LEN_W].
- o_tx_dv  out  1  one-cycle strobe; o_tx_byte is to be sent.
- o_tx_byte  out  8  byte to transmit; held stable until the next o_tx_dv.
- o_busy  out  1  high from command acceptance until the last byte's i_tx_done.
- o_drop_cnt  out  8  saturating count of i_rx_dv strobes ignored while busy.

Behaviour:
- Clock/reset: single clock i_clk_10; i_rst synchronous, active-high.
- Reset values: o_tx_dv=0, o_tx_byte=8'h00, o_busy=0, o_drop_cnt=0, state=IDLE, index=0, snapshot=0, checksum=0.
- States: IDLE, SEND, WAIT, CSUM (CSUM exists only with the optional feature).
- IDLE, on i_rx_dv=1 at edge t:
  - Byte in range CMD_BASE..CMD_BASE+N_SRC-1 (8-bit compare, no wrap past 8'hFF):
    - latch sel, snapshot i_src_data[sel] and len=min(i_src_len[sel], MAX_BYTES);
    - o_busy=1 and o_tx_dv=1 with o_tx_byte=command byte in cycle t+1;
    - go to WAIT with index=0.
  - Any other byte with ECHO_UNKNOWN=1: o_tx_dv pulse in t+1 carrying the byte; o_busy=1 until its i_tx_done; no payload.
  - Any other byte with ECHO_UNKNOWN=0: no action.
- WAIT:
  - Hold until i_tx_done.
  - If index<len: go to SEND.
  - Else: go to CSUM if enabled, otherwise IDLE with o_busy=0 in the cycle after i_tx_done.
- SEND: o_tx_dv=1 for exactly one cycle with o_tx_byte=snapshot byte[index]; index+1; return to WAIT.
- Byte latency: i_tx_done at cycle d gives the next o_tx_dv at d+2 (WAIT→SEND edge, then the SEND output).
- Byte order: command echo, then payload bytes 0..len-1, LSB byte first.
- Zero length: only the command echo is sent.
- Over-length: len>MAX_BYTES is clipped to MAX_BYTES.
- Snapshot: source changes after acceptance do not affect the frame in flight.
- i_rx_dv while o_busy=1 (including the same cycle as i_tx_done): byte discarded; o_drop_cnt+1, saturating at 8'hFF.
- New command on the final i_tx_done cycle: dropped; o_busy still high that cycle.
- Spurious i_tx_done in IDLE or SEND: ignored.
- Reset mid-frame: immediate return to IDLE with reset values; no further bytes sent.
- index width: $clog2(MAX_BYTES+1); no wrap possible because len≤MAX_BYTES.

Optional Feature:
- Macro: UART_DUMP_CSUM_EN.
- Defined:
  - After the last payload i_tx_done, CSUM sends one extra byte equal to the XOR of the command echo and all payload bytes.
  - Frame length is len+2.
  - o_busy drops after the checksum's i_tx_done.
  - A zero-length frame's checksum equals the command byte.
- Undefined: no CSUM state or checksum register; frame length is len+1.

Decomposition:
- Package uart_dump_pkg:
  - state enum (IDLE/SEND/WAIT/CSUM);
  - default command constants (CMD_REG=8'hAB, CMD_THUNDER=8'hAC, CMD_EASTER=8'hAD under the default base);
  - function for the in-range command check.
- Sub-module dump_snapshot_sel: registered capture of the selected source vector and clipped length on a load strobe, plus a combinational byte mux by index. The top level keeps the FSM, counters and handshake.

Test Plan:
- Source 0 len=26, bytes 0x00..0x19; send 8'hAB; tx-done model 10 cycles after each dv → 27 dv strobes: AB,00,01..19; o_busy falls after the 27th done; o_drop_cnt=0.
- Source 2 len=2, data CA,FE; send 8'hAD → AD,CA,FE. With UART_DUMP_CSUM_EN: AD,CA,FE,99 (AD^CA^FE=0x99).
- Send 8'h41 with ECHO_UNKNOWN=1 → single dv with 0x41, no payload. With ECHO_UNKNOWN=0 → no dv; o_busy stays 0.
- During a source-1 (len=17) frame, inject 300 i_rx_dv strobes of 8'hAB → frame unchanged (18 bytes); o_drop_cnt=8'hFF (saturated).
- Change i_src_data source 0 byte 5 from 0x05 to 0x77 after acceptance → transmitted byte 5 is still 0x05. i_src_len=40 → exactly 32 payload bytes. len=0 → only AB.
- Assert i_rst after the 3rd payload byte → o_tx_dv=0, o_tx_byte=00, o_busy=0 next cycle; no further dv; a fresh 8'hAB then yields a complete frame.

Source files
------------

// File: rtl/uart_dump_pkg.sv
// Shared types and constants for the UART dump controller.
// With UART_DUMP_CSUM_EN defined, the state enum gains the checksum-trailer state.
package uart_dump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
`ifdef UART_DUMP_CSUM_EN
    WAIT = 2'd2,
    CSUM = 2'd3
`else
    WAIT = 2'd2
`endif
  } state_t;

  localparam logic [7:0] CMD_REG     = 8'hAB;
  localparam logic [7:0] CMD_THUNDER = 8'hAC;
  localparam logic [7:0] CMD_EASTER  = 8'hAD;

  // Integer compare so a window near 8'hFF never wraps back to low byte values.
  function automatic logic cmd_in_range(input logic [7:0] cmd, input logic [7:0] base,
                                        input int unsigned n_src);
    int unsigned c;
    int unsigned b;
    c = 32'(cmd);
    b = 32'(base);
    return (c >= b) && (c < (b + n_src));
  endfunction

endpackage

// File: rtl/uart_dump_ctrl_n_if.sv
// Byte handshake between the dump controller and the UART rx/tx pair.
interface uart_dump_ctrl_n_if;
  logic [7:0] rx_byte;
  logic       rx_dv;
  logic       tx_done;
  logic       tx_dv;
  logic [7:0] tx_byte;

  modport slave  (input rx_byte, rx_dv, tx_done, output tx_dv, tx_byte);
  modport master (output rx_byte, rx_dv, tx_done, input tx_dv, tx_byte);
endinterface

// File: rtl/dump_snapshot_sel.sv
// Captures the selected source vector and its clipped length on load,
// and presents the snapshot byte addressed by index.
module dump_snapshot_sel #(
  parameter int N_SRC     = 3,
  parameter int MAX_BYTES = 32,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1),
  parameter int SEL_W     = 2
) (
  input  logic                         i_clk_10,
  input  logic                         i_rst,
  input  logic                         load,
  input  logic [SEL_W-1:0]             sel,
  input  logic [N_SRC*MAX_BYTES*8-1:0] src_data,
  input  logic [N_SRC*LEN_W-1:0]       src_len,
  input  logic [LEN_W-1:0]             index,
  output logic [LEN_W-1:0]             len_r,
  output logic [7:0]                   byte_s
);

  localparam int VEC_W = MAX_BYTES * 8;

  logic [VEC_W-1:0] vec_s;
  logic [LEN_W-1:0] raw_len_s;
  logic [LEN_W-1:0] clip_len_s;
  logic [VEC_W-1:0] snap_r;

  // Select the requested source and clip its length to the vector size.
  always_comb begin
    vec_s      = '0;
    raw_len_s  = '0;
    clip_len_s = '0;
    if (int'(sel) < N_SRC) begin
      vec_s     = src_data[int'(sel)*VEC_W +: VEC_W];
      raw_len_s = src_len[int'(sel)*LEN_W +: LEN_W];
    end else begin
      vec_s     = '0;
      raw_len_s = '0;
    end
    if (raw_len_s > LEN_W'(MAX_BYTES)) begin
      clip_len_s = LEN_W'(MAX_BYTES);
    end else begin
      clip_len_s = raw_len_s;
    end
  end

  // Snapshot register, frozen for the whole frame once loaded.
  always_ff @(posedge i_clk_10) begin
    if (i_rst) begin
      snap_r <= '0;
      len_r  <= '0;
    end else if (load) begin
      snap_r <= vec_s;
      len_r  <= clip_len_s;
    end
  end

  // Byte mux by payload index.
  always_comb begin
    byte_s = 8'h00;
    if (int'(index) < MAX_BYTES) begin
      byte_s = snap_r[int'(index)*8 +: 8];
    end else begin
      byte_s = 8'h00;
    end
  end

endmodule

// File: rtl/uart_dump_ctrl_n.sv
// UART command responder: a command byte selects a source which is echoed and dumped byte by byte.
// Define UART_DUMP_CSUM_EN to append an XOR checksum byte to each command frame.
module uart_dump_ctrl_n
  import uart_dump_pkg::*;
#(
  parameter int         N_SRC        = 3,
  parameter int         MAX_BYTES    = 32,
  parameter int         LEN_W        = $clog2(MAX_BYTES + 1),
  parameter logic [7:0] CMD_BASE     = 8'hAB,
  parameter int         ECHO_UNKNOWN = 1
) (
  input  logic                         i_clk_10,
  input  logic                         i_rst,
  uart_dump_ctrl_n_if.slave            uart,
  input  logic [N_SRC*MAX_BYTES*8-1:0] i_src_data,
  input  logic [N_SRC*LEN_W-1:0]       i_src_len,
  output logic                         o_busy,
  output logic [7:0]                   o_drop_cnt
);

  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  state_t           state_r;
  logic [LEN_W-1:0] index_r;
  logic             echo_only_r;
  logic             tx_dv_r;
  logic [7:0]       tx_byte_r;
  logic             busy_r;
  logic [7:0]       drop_cnt_r;
`ifdef UART_DUMP_CSUM_EN
  logic [7:0]       csum_r;
  logic             csum_sent_r;
`endif

  logic             cmd_hit_s;
  logic             load_s;
  logic [SEL_W-1:0] sel_s;
  logic [LEN_W-1:0] len_r;
  logic [7:0]       byte_s;

  // Command decode and snapshot load strobe.
  always_comb begin
    cmd_hit_s = cmd_in_range(uart.rx_byte, CMD_BASE, N_SRC);
    sel_s     = SEL_W'(uart.rx_byte - CMD_BASE);
    load_s    = (state_r == IDLE) && uart.rx_dv && cmd_hit_s;
  end

  dump_snapshot_sel #(
    .N_SRC     (N_SRC),
    .MAX_BYTES (MAX_BYTES),
    .LEN_W     (LEN_W),
    .SEL_W     (SEL_W)
  ) u_snap (
    .i_clk_10 (i_clk_10),
    .i_rst    (i_rst),
    .load     (load_s),
    .sel      (sel_s),
    .src_data (i_src_data),
    .src_len  (i_src_len),
    .index    (index_r),
    .len_r    (len_r),
    .byte_s   (byte_s)
  );

  // Saturating count of bytes that arrive while a frame is in flight.
  always_ff @(posedge i_clk_10) begin
    if (i_rst) begin
      drop_cnt_r <= 8'h00;
    end else if (uart.rx_dv && busy_r && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_r <= drop_cnt_r + 8'h01;
    end
  end

  // Frame sequencer: echo, payload bytes, optional checksum, each paced by tx_done.
  always_ff @(posedge i_clk_10) begin
    if (i_rst) begin
      state_r     <= IDLE;
      index_r     <= '0;
      echo_only_r <= 1'b0;
      tx_dv_r     <= 1'b0;
      tx_byte_r   <= 8'h00;
      busy_r      <= 1'b0;
`ifdef UART_DUMP_CSUM_EN
      csum_r      <= 8'h00;
      csum_sent_r <= 1'b0;
`endif
    end else begin
      tx_dv_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (uart.rx_dv && cmd_hit_s) begin
            tx_dv_r     <= 1'b1;
            tx_byte_r   <= uart.rx_byte;
            busy_r      <= 1'b1;
            index_r     <= '0;
            echo_only_r <= 1'b0;
            state_r     <= WAIT;
`ifdef UART_DUMP_CSUM_EN
            csum_r      <= uart.rx_byte;
            csum_sent_r <= 1'b0;
`endif
          end else if (uart.rx_dv && (ECHO_UNKNOWN != 0)) begin
            tx_dv_r     <= 1'b1;
            tx_byte_r   <= uart.rx_byte;
            busy_r      <= 1'b1;
            index_r     <= '0;
            echo_only_r <= 1'b1;
            state_r     <= WAIT;
          end
        end
        WAIT: begin
          if (uart.tx_done) begin
            if (!echo_only_r && (index_r < len_r)) begin
              state_r <= SEND;
`ifdef UART_DUMP_CSUM_EN
            end else if (!echo_only_r && !csum_sent_r) begin
              state_r <= CSUM;
`endif
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end
        end
        SEND: begin
          tx_dv_r   <= 1'b1;
          tx_byte_r <= byte_s;
          index_r   <= index_r + LEN_W'(1);
          state_r   <= WAIT;
`ifdef UART_DUMP_CSUM_EN
          csum_r    <= csum_r ^ byte_s;
`endif
        end
`ifdef UART_DUMP_CSUM_EN
        CSUM: begin
          tx_dv_r     <= 1'b1;
          tx_byte_r   <= csum_r;
          csum_sent_r <= 1'b1;
          state_r     <= WAIT;
        end
`endif
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign uart.tx_dv   = tx_dv_r;
  assign uart.tx_byte = tx_byte_r;
  assign o_busy       = busy_r;
  assign o_drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_uart_dump_ctrl_n.sv
// Directed bench for uart_dump_ctrl_n with a transmitter model that returns tx_done after a fixed delay.
module tb_uart_dump_ctrl_n;

  localparam int N_SRC     = 3;
  localparam int MAX_BYTES = 32;
  localparam int LEN_W     = $clog2(MAX_BYTES + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N_SRC*MAX_BYTES*8-1:0] src_data = '0;
  logic [N_SRC*LEN_W-1:0]       src_len  = '0;
  logic       busy, busy_n;
  logic [7:0] drop_cnt, drop_n;

  uart_dump_ctrl_n_if bus ();
  uart_dump_ctrl_n_if bus_n ();

  uart_dump_ctrl_n #(.ECHO_UNKNOWN(1)) dut (
    .i_clk_10 (clk), .i_rst (rst), .uart (bus.slave),
    .i_src_data (src_data), .i_src_len (src_len),
    .o_busy (busy), .o_drop_cnt (drop_cnt)
  );

  uart_dump_ctrl_n #(.ECHO_UNKNOWN(0)) dut_n (
    .i_clk_10 (clk), .i_rst (rst), .uart (bus_n.slave),
    .i_src_data (src_data), .i_src_len (src_len),
    .o_busy (busy_n), .o_drop_cnt (drop_n)
  );

  always #50 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_delay = 10;
  int cd = 0;
  int done_cnt = 0;
  int n_dv_cnt = 0;
  logic [7:0] cap[$];
  logic [7:0] exp_q[$];

  // Transmitter model: one tx_done strobe done_delay cycles after each tx_dv.
  always @(negedge clk) begin
    if (rst) begin
      cd = 0;
      bus.tx_done = 1'b0;
    end else begin
      bus.tx_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) bus.tx_done = 1'b1;
      end
      if (bus.tx_dv) cd = done_delay;
    end
  end

  always @(negedge clk) if (bus.tx_dv) cap.push_back(bus.tx_byte);
  always @(negedge clk) if (bus_n.tx_dv) n_dv_cnt++;
  always @(posedge clk) if (bus.tx_done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_byte(input int s, input int b, input logic [7:0] v);
    src_data[(s*MAX_BYTES+b)*8 +: 8] = v;
  endtask

  task automatic set_len(input int s, input int l);
    src_len[s*LEN_W +: LEN_W] = LEN_W'(l);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    bus.rx_byte = b;
    bus.rx_dv   = 1'b1;
    @(negedge clk);
    bus.rx_dv   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_count"}, cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < cap.size()) chk($sformatf("%s_byte%0d", tag, i), 32'(cap[i]), 32'(exp_q[i]));
    end
    chk({tag, "_dones"}, done_cnt, cap.size());
  endtask

  task automatic run_frame(input logic [7:0] cmd, input string tag);
    cap.delete();
    done_cnt = 0;
    send_cmd(cmd);
    wait_idle(3000);
    check_frame(tag);
  endtask

  task automatic exp_src0(input int n);
    exp_q.delete();
    exp_q.push_back(8'hAB);
    for (int i = 0; i < n; i++) exp_q.push_back(8'(i));
  endtask

  initial begin
    bus.rx_byte = 8'h00; bus.rx_dv = 1'b0;
    bus_n.rx_byte = 8'h00; bus_n.rx_dv = 1'b0; bus_n.tx_done = 1'b0;
    for (int b = 0; b < MAX_BYTES; b++) set_byte(0, b, 8'(b));
    for (int b = 0; b < 17; b++) set_byte(1, b, 8'h30 + 8'(b));
    set_byte(2, 0, 8'hCA);
    set_byte(2, 1, 8'hFE);
    set_len(0, 26); set_len(1, 17); set_len(2, 2);

    repeat (3) @(negedge clk);
    chk("rst_tx_dv", 32'(bus.tx_dv), 32'd0);
    chk("rst_tx_byte", 32'(bus.tx_byte), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Source 0, 26 bytes.
    exp_src0(26);
`ifdef UART_DUMP_CSUM_EN
    exp_q.push_back(8'hAA);
`endif
    run_frame(8'hAB, "src0");
    chk("src0_drop", 32'(drop_cnt), 32'h00);

    // Source 2, CA FE.
    exp_q.delete();
    exp_q.push_back(8'hAD); exp_q.push_back(8'hCA); exp_q.push_back(8'hFE);
`ifdef UART_DUMP_CSUM_EN
    exp_q.push_back(8'h99);
`endif
    run_frame(8'hAD, "src2");

    // Unknown byte: echoed by one instance, ignored by the other.
    exp_q.delete();
    exp_q.push_back(8'h41);
    run_frame(8'h41, "echo");
    @(negedge clk);
    bus_n.rx_byte = 8'h41;
    bus_n.rx_dv   = 1'b1;
    @(negedge clk);
    bus_n.rx_dv   = 1'b0;
    chk("noecho_busy_now", 32'(busy_n), 32'd0);
    repeat (20) @(negedge clk);
    chk("noecho_dv", n_dv_cnt, 32'd0);
    chk("noecho_busy", 32'(busy_n), 32'd0);

    // Snapshot coherence: byte 5 changed after acceptance.
    exp_src0(26);
`ifdef UART_DUMP_CSUM_EN
    exp_q.push_back(8'hAA);
`endif
    cap.delete();
    done_cnt = 0;
    send_cmd(8'hAB);
    set_byte(0, 5, 8'h77);
    wait_idle(3000);
    check_frame("snap");
    set_byte(0, 5, 8'h05);

    // Over-length clipped to 32.
    set_len(0, 40);
    exp_src0(32);
`ifdef UART_DUMP_CSUM_EN
    exp_q.push_back(8'hAB);
`endif
    run_frame(8'hAB, "clip");

    // Zero length: echo only.
    set_len(0, 0);
    exp_src0(0);
`ifdef UART_DUMP_CSUM_EN
    exp_q.push_back(8'hAB);
`endif
    run_frame(8'hAB, "zero");
    set_len(0, 26);

    // 300 commands during a source-1 frame are all dropped.
    done_delay = 20;
    exp_q.delete();
    exp_q.push_back(8'hAC);
    for (int i = 0; i < 17; i++) exp_q.push_back(8'h30 + 8'(i));
`ifdef UART_DUMP_CSUM_EN
    exp_q.push_back(8'hEC);
`endif
    cap.delete();
    done_cnt = 0;
    send_cmd(8'hAC);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus.rx_byte = 8'hAB;
      bus.rx_dv   = 1'b1;
    end
    @(negedge clk);
    bus.rx_dv = 1'b0;
    chk("drop_busy_held", 32'(busy), 32'd1);
    wait_idle(3000);
    check_frame("drop");
    chk("drop_sat", 32'(drop_cnt), 32'hFF);
    done_delay = 10;

    // Reset after the third payload byte.
    cap.delete();
    done_cnt = 0;
    send_cmd(8'hAB);
    for (int n = 0; n < 1000 && cap.size() < 4; n++) @(negedge clk);
    chk("mid_cap_reached", cap.size(), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx_dv", 32'(bus.tx_dv), 32'd0);
    chk("mid_rst_tx_byte", 32'(bus.tx_byte), 32'h00);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt), 32'h00);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_no_more_dv", cap.size(), 32'd4);
    if (cap.size() >= 4) chk("mid_third_payload", 32'(cap[3]), 32'h02);
    exp_src0(26);
`ifdef UART_DUMP_CSUM_EN
    exp_q.push_back(8'hAA);
`endif
    run_frame(8'hAB, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
